uart_rx_ctrl: RTL and testbench

- Receive-side sequencer for the UART RX path.
- Detects the start bit, oversamples each bit with a 3-point majority vote, and drives the deserializer through `deser_en`, `sampled_bit` and `remove_data`.
- Checks parity and stop bits, then flags a completed frame with `data_valid`.
- Sits between the (already synchronized) serial input and the deserializer / output register stage.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_edge_bit_cnt.sv | 68 ++++++
 rtl/uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_e  receive sequencer states
//   PAR_EVEN / PAR_ODD  encodings of the par_typ input
//   majority3   2-of-3 vote used for bit oversampling
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter for the UART receiver.
//   clk, rst     clock, synchronous active-high reset
//   prescale     oversampling ratio of the current frame
//   clr          force both counters to 0 (priority over edge_en)
//   edge_en      advance edge_cnt; wraps to 0 after prescale-1
//   bit_en       advance bit_cnt at each bit end
//   bit_cnt      number of completed bits since the last clear
//   samp_lo      edge_cnt == prescale/2 - 1 (first sample)
//   samp_mid     edge_cnt == prescale/2     (second sample)
//   samp_pt      edge_cnt == prescale/2 + 1 (third sample, vote cycle)
//   bit_end      edge_cnt == prescale - 1
module uart_rx_edge_bit_cnt #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr,
    input  logic                  edge_en,
    input  logic                  bit_en,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  samp_lo,
    output logic                  samp_mid,
    output logic                  samp_pt,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_W-1:0] half;

    assign half = prescale >> 1;

    always_comb begin
        samp_lo  = (edge_cnt_q == half - PRESCALE_W'(1));
        samp_mid = (edge_cnt_q == half);
        samp_pt  = (edge_cnt_q == half + PRESCALE_W'(1));
        bit_end  = (edge_cnt_q == prescale - PRESCALE_W'(1));
    end

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (edge_en) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (bit_en && bit_end) begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, 3-point majority oversampling,
// deserializer strobes, parity and stop checking.
//   clk, rst     clock, synchronous active-high reset
//   rx_in        synchronized serial line, idle high
//   prescale     oversampling ratio (even, 8..32), latched at start detection
//   par_en       frame carries a parity bit (latched at start detection)
//   par_typ      0 even / 1 odd parity (latched at start detection)
//   sampled_bit  voted value of the most recent bit
//   deser_en     strobe: deserializer shifts in sampled_bit
//   remove_data  strobe: deserializer clears its register
//   data_valid   pulse: frame received without error
//   par_err      parity mismatch, held until the next start
//   stp_err      stop bit low, held until the next start
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  sampled_bit,
    output logic                  deser_en,
    output logic                  remove_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

    rx_state_e state_q, state_d;

    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  par_acc_q, par_acc_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  deser_en_q, deser_en_d;
    logic                  remove_data_q, remove_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  bit_en;
    logic [PRESCALE_W-1:0] cnt_prescale;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  samp_lo;
    logic                  samp_mid;
    logic                  samp_pt;
    logic                  bit_end;
    logic                  vote;

    // The detection cycle is edge 0 of the start bit, so the counter must
    // already see the new ratio before the latched copy is updated.
    assign cnt_prescale = (state_q == IDLE) ? prescale : prescale_q;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .prescale (cnt_prescale),
        .clr      (cnt_clr),
        .edge_en  (cnt_en),
        .bit_en   (bit_en),
        .bit_cnt  (bit_cnt),
        .samp_lo  (samp_lo),
        .samp_mid (samp_mid),
        .samp_pt  (samp_pt),
        .bit_end  (bit_end)
    );

    // Third sample is the live input on the vote cycle.
    assign vote = majority3(s0_q, s1_q, rx_in);

    always_comb begin
        state_d       = state_q;
        prescale_d    = prescale_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        s0_d          = samp_lo  ? rx_in : s0_q;
        s1_d          = samp_mid ? rx_in : s1_q;
        par_acc_d     = par_acc_q;
        sampled_bit_d = sampled_bit_q;
        deser_en_d    = 1'b0;
        remove_data_d = 1'b0;
        data_valid_d  = 1'b0;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b1;
        bit_en        = 1'b0;

        if (state_q != IDLE && samp_pt) begin
            sampled_bit_d = vote;
        end

        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                cnt_en  = 1'b0;
                if (!rx_in) begin
                    state_d       = START;
                    cnt_clr       = 1'b0;
                    cnt_en        = 1'b1;
                    prescale_d    = prescale;
                    par_en_d      = par_en;
                    par_typ_d     = par_typ;
                    par_acc_d     = 1'b0;
                    remove_data_d = 1'b1;
                    par_err_d     = 1'b0;
                    stp_err_d     = 1'b0;
                end
            end
            START: begin
                if (samp_pt && vote) begin
                    // Start bit did not hold low: treat as a line glitch.
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                bit_en = 1'b1;
                if (samp_pt) begin
                    deser_en_d = 1'b1;
                    par_acc_d  = par_acc_q ^ vote;
                end
                if (bit_end && bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (samp_pt) begin
                    par_err_d = vote != (par_acc_q ^ (par_typ_q == PAR_ODD));
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (samp_pt) begin
                    // Leave before the stop bit ends so a following start bit
                    // is caught on its first edge.
                    stp_err_d    = ~vote;
                    data_valid_d = vote & ~par_err_q;
                    state_d      = IDLE;
                    cnt_clr      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            prescale_q    <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            s0_q          <= 1'b0;
            s1_q          <= 1'b0;
            par_acc_q     <= 1'b0;
            sampled_bit_q <= 1'b0;
            deser_en_q    <= 1'b0;
            remove_data_q <= 1'b0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            par_acc_q     <= par_acc_d;
            sampled_bit_q <= sampled_bit_d;
            deser_en_q    <= deser_en_d;
            remove_data_q <= remove_data_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign deser_en    = deser_en_q;
    assign remove_data = remove_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the frame model pushes expected events
// (with their cycle offset from remove_data) and a monitor pops and compares.
module tb_uart_rx_ctrl;

    localparam int DATA_W = 8;
    localparam int PW     = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          sampled_bit;
    logic          deser_en;
    logic          remove_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_ctrl #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .deser_en    (deser_en),
        .remove_data (remove_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_RM, EV_BIT, EV_PERR, EV_SERR, EV_VALID} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        logic     val;
        int       rel;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   t0 = 0;
    logic prev_p = 1'b0;
    logic prev_s = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input ev_kind_e k, input logic v, input int rel);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.rel  = rel;
        exp_q.push_back(e);
    endfunction

    task automatic expect_ev(input ev_kind_e k, input logic v);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s actual=event required=none (cycle %0d)", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            chk({"ev_kind_", k.name()}, int'(k), int'(e.kind));
            chk({"ev_value_", k.name()}, int'(v), int'(e.val));
            chk({"ev_time_", k.name()}, cyc - t0, e.rel);
        end
    endtask

    // Monitor: sample outputs 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (remove_data) begin
                t0 = cyc;
                expect_ev(EV_RM, 1'b1);
                chk("err_clear_on_start", int'({par_err, stp_err}), 0);
            end
            if (deser_en) expect_ev(EV_BIT, sampled_bit);
            if (par_err && !prev_p) expect_ev(EV_PERR, 1'b1);
            if (stp_err && !prev_s) expect_ev(EV_SERR, 1'b1);
            if (data_valid) begin
                expect_ev(EV_VALID, 1'b1);
                chk("no_err_on_valid", int'({par_err, stp_err}), 0);
            end
            prev_p = par_err;
            prev_s = stp_err;
        end
    end

    // Hold the line at b for n rising edges, ending 1 unit after the last one.
    task automatic drive_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: event k of a frame occurs at the sample point of line
    // bit b, i.e. 1 + p/2 + b*p cycles after remove_data is seen.
    task automatic send_frame(input int p, input logic [7:0] data, input logic pe,
                              input logic pt, input logic flip, input logic stop_bit,
                              input logic scramble);
        int   h;
        int   sb;
        logic par;
        h   = p / 2;
        sb  = DATA_W + 1 + int'(pe);
        par = (^data) ^ pt ^ flip;
        prescale = PW'(p);
        par_en   = pe;
        par_typ  = pt;
        push(EV_RM, 1'b1, 0);
        for (int i = 0; i < DATA_W; i++) push(EV_BIT, data[i], 1 + h + (i + 1) * p);
        if (pe && flip) push(EV_PERR, 1'b1, 1 + h + (DATA_W + 1) * p);
        if (!stop_bit) push(EV_SERR, 1'b1, 1 + h + sb * p);
        if (!(pe && flip) && stop_bit) push(EV_VALID, 1'b1, 1 + h + sb * p);
        drive_bit(1'b0, p);
        if (scramble) begin
            prescale = PW'(2 * $urandom_range(4, 16));
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
        end
        for (int i = 0; i < DATA_W; i++) drive_bit(data[i], p);
        if (pe) drive_bit(par, p);
        if (stop_bit) begin
            drive_bit(1'b1, p);
        end else begin
            // Release a low stop bit right after its samples so the line does
            // not read as a new start bit.
            drive_bit(1'b0, h + 2);
            drive_bit(1'b1, p - h - 2);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_sampled_bit"}, int'(sampled_bit), 0);
        chk({tag, "_deser_en"}, int'(deser_en), 0);
        chk({tag, "_remove_data"}, int'(remove_data), 0);
        chk({tag, "_data_valid"}, int'(data_valid), 0);
        chk({tag, "_par_err"}, int'(par_err), 0);
        chk({tag, "_stp_err"}, int'(stp_err), 0);
    endtask

    initial begin
        logic [7:0] d;
        int         p;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        drive_bit(1'b1, 4);

        // Plain 8N1 frame.
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 3);

        // Even parity: correct, then wrong parity bit.
        send_frame(16, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(16, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 5);
        chk("par_err_held", int'(par_err), 1);

        // Framing error, held until the next start.
        send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 5);
        chk("stp_err_held", int'(stp_err), 1);

        // Start-bit glitch, then a frame starting at edge 6 of the glitch.
        prescale = PW'(8);
        push(EV_RM, 1'b1, 0);
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 4);
        send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back frames at the largest ratio.
        send_frame(32, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(32, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during the 4th data bit.
        prescale = PW'(8);
        par_en   = 1'b0;
        d        = 8'hC6;
        push(EV_RM, 1'b1, 0);
        for (int i = 0; i < 3; i++) push(EV_BIT, d[i], 1 + 4 + (i + 1) * 8);
        drive_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
        drive_bit(d[3], 2);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midframe_reset");
        rst = 1'b0;
        chk("reset_pending_events", exp_q.size(), 0);
        exp_q.delete();
        drive_bit(1'b1, 16);
        send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized frames with mid-frame configuration changes.
        for (int n = 0; n < 25; n++) begin
            p = 2 * $urandom_range(4, 16);
            send_frame(p, 8'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0, 1'b1);
            if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 4));
        end

        drive_bit(1'b1, 20);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
